// File: rtl/tft_pkg.sv
// Shared constants for the TFT pattern sequencer: panel geometry, RGB888
// colours, sequencer state encoding and colour lookups for the banded patterns.
package tft_pkg;

    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 480;

    localparam logic [23:0] BLACK  = 24'h000000;
    localparam logic [23:0] BLUE   = 24'h0000FF;
    localparam logic [23:0] RED    = 24'hFF0000;
    localparam logic [23:0] PURPLE = 24'hFF00FF;
    localparam logic [23:0] GREEN  = 24'h00FF00;
    localparam logic [23:0] CYAN   = 24'h00FFFF;
    localparam logic [23:0] YELLOW = 24'hFFFF00;
    localparam logic [23:0] WHITE  = 24'hFFFFFF;

    typedef enum logic [1:0] {
        ST_BL_OFF = 2'd0,
        ST_RAMP   = 2'd1,
        ST_RUN    = 2'd2,
        ST_PAUSE  = 2'd3
    } seq_state_t;

    // Colour grid, indexed by {row[1:0], col}: left column dark, right column bright.
    function automatic logic [23:0] grid_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = BLACK;
            3'd1:    c = BLUE;
            3'd2:    c = RED;
            3'd3:    c = PURPLE;
            3'd4:    c = GREEN;
            3'd5:    c = CYAN;
            3'd6:    c = YELLOW;
            default: c = WHITE;
        endcase
        return c;
    endfunction

    // Classic colour bars, left to right.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = WHITE;
            3'd1:    c = YELLOW;
            3'd2:    c = CYAN;
            3'd3:    c = GREEN;
            3'd4:    c = PURPLE;
            3'd5:    c = RED;
            3'd6:    c = BLUE;
            default: c = BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tft_pattern_rom.sv
// Combinational test-pattern generator: maps (pattern, column, row) to RGB888.
module tft_pattern_rom
    import tft_pkg::*;
(
    input  logic [2:0]  pattern_id,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    output logic [23:0] pixel
);

    logic [1:0] row;
    logic       col;
    logic [2:0] bar;
    logic [7:0] level;
    logic       border;

    // Decode position into grid cell, bar index, ramp level and border hit.
    // Compare chains keep the fixed 120-row / 100-column splits divider-free.
    always_comb begin
        if (vcount < 11'd120)      row = 2'd0;
        else if (vcount < 11'd240) row = 2'd1;
        else if (vcount < 11'd360) row = 2'd2;
        else                       row = 2'd3;

        col = (hcount >= 11'd400);

        if (hcount < 11'd100)      bar = 3'd0;
        else if (hcount < 11'd200) bar = 3'd1;
        else if (hcount < 11'd300) bar = 3'd2;
        else if (hcount < 11'd400) bar = 3'd3;
        else if (hcount < 11'd500) bar = 3'd4;
        else if (hcount < 11'd600) bar = 3'd5;
        else if (hcount < 11'd700) bar = 3'd6;
        else                       bar = 3'd7;

        // hcount[9:2] would wrap past 1023, so clamp the ramp at full scale.
        level = (hcount >= 11'd1020) ? 8'hFF : hcount[9:2];

        border = (hcount == 11'd0) || (hcount == 11'(H_ACTIVE - 1)) ||
                 (vcount == 11'd0) || (vcount == 11'(V_ACTIVE - 1));
    end

    // Select the colour for the requested pattern.
    always_comb begin
        case (pattern_id)
            3'd0:    pixel = grid_colour({row, col});
            3'd1:    pixel = bar_colour(bar);
            3'd2:    pixel = {level, level, level};
            3'd3:    pixel = (hcount[5] ^ vcount[5]) ? WHITE : BLACK;
            3'd4:    pixel = RED;
            3'd5:    pixel = GREEN;
            3'd6:    pixel = BLUE;
            default: pixel = border ? WHITE : BLACK;
        endcase
    end

endmodule

// File: rtl/tft_pattern_sequencer.sv
// Panel bring-up sequencer: warm-up with backlight off, backlight PWM ramp,
// then an auto-advancing test-pattern slideshow with pause / next keys.
// All pattern and duty changes happen on frame_tick (start of vertical sync).
module tft_pattern_sequencer
    import tft_pkg::*;
#(
    parameter int WARMUP_FRAMES = 30,
    parameter int BL_STEP       = 8,
    parameter int DWELL_FRAMES  = 120
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        vs_in,
    input  logic        Data_Req,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        key_next,
    input  logic        key_pause,
    output logic [23:0] disp_data,
    output logic        TFT_BL,
    output logic [2:0]  pattern_id,
    output logic [1:0]  seq_state
);

    localparam int FW = $clog2(WARMUP_FRAMES + 1);
    localparam int DW = $clog2(DWELL_FRAMES + 1);

    seq_state_t    state, state_nxt;
    logic [FW-1:0] frame_cnt, frame_nxt;
    logic [DW-1:0] dwell, dwell_nxt;
    logic [7:0]    duty, duty_nxt;
    logic [2:0]    pat_nxt;
    logic          next_pend, pend_nxt;
    logic          running;

    logic          vs_prev;
    logic          frame_tick;
    logic [7:0]    pwm_cnt;
    logic [8:0]    duty_sum;
    logic [7:0]    duty_sat;
    logic [23:0]   pixel;

    assign seq_state = state;

    // Registered falling-edge detect on the active-low vertical sync.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_prev    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vs_prev    <= vs_in;
            frame_tick <= vs_prev & ~vs_in;
        end
    end

    // Saturating ramp step; the carry bit flags an overshoot past 255.
    assign duty_sum = {1'b0, duty} + 9'(BL_STEP);
    assign duty_sat = duty_sum[8] ? 8'hFF : duty_sum[7:0];

    // Next-state logic. Frame work happens on frame_tick; keys act at once.
    always_comb begin
        state_nxt = state;
        frame_nxt = frame_cnt;
        duty_nxt  = duty;
        dwell_nxt = dwell;
        pat_nxt   = pattern_id;
        pend_nxt  = next_pend;
        running   = (state == ST_RUN) || (state == ST_PAUSE);

        if (frame_tick) begin
            pend_nxt = 1'b0;
            unique case (state)
                ST_BL_OFF: begin
                    frame_nxt = frame_cnt + 1'b1;
                    if (frame_cnt == FW'(WARMUP_FRAMES - 1))
                        state_nxt = ST_RAMP;
                end
                ST_RAMP: begin
                    duty_nxt = duty_sat;
                    if (duty_sat == 8'hFF)
                        state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    // Expiry and a pending key on the same tick still advance once.
                    if (next_pend || (dwell == DW'(DWELL_FRAMES - 1))) begin
                        pat_nxt   = pattern_id + 3'd1;
                        dwell_nxt = '0;
                    end else begin
                        dwell_nxt = dwell + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (next_pend) begin
                        pat_nxt   = pattern_id + 3'd1;
                        dwell_nxt = '0;
                    end
                end
            endcase
        end

        // A key arriving on the tick cycle is kept for the following frame.
        if (running && key_next)
            pend_nxt = 1'b1;
        if (running && key_pause)
            state_nxt = (state == ST_RUN) ? ST_PAUSE : ST_RUN;
    end

    // Sequencer state and frame-rate counters.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_BL_OFF;
            frame_cnt  <= '0;
            dwell      <= '0;
            duty       <= 8'd0;
            pattern_id <= 3'd0;
            next_pend  <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_cnt  <= frame_nxt;
            dwell      <= dwell_nxt;
            duty       <= duty_nxt;
            pattern_id <= pat_nxt;
            next_pend  <= pend_nxt;
        end
    end

    // Free-running 8-bit PWM; duty 255 leaves one off cycle per period.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pwm_cnt <= 8'd0;
            TFT_BL  <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            TFT_BL  <= (pwm_cnt < duty);
        end
    end

    tft_pattern_rom u_rom (
        .pattern_id (pattern_id),
        .hcount     (hcount),
        .vcount     (vcount),
        .pixel      (pixel)
    );

    // One-cycle pixel pipeline; black outside requests and before the slideshow.
    always_ff @(posedge Clk) begin
        if (Reset)
            disp_data <= BLACK;
        else
            disp_data <= (Data_Req && running) ? pixel : BLACK;
    end

endmodule
